msi_tag_state_ctrl: RTL and testbench
=====================================

// Module: msi_tag_state_ctrl
// PURPOSE
//  Sequences all reads/writes of the 2-bit MSI state field held in the way0/way1 tag arrays of the 2-way L1.
//  Arbitrates between the local CPU port and the bus snoop port, one read-modify-write at a time.
//  Computes each next MSI state and the bus action it needs; sits between the hit/miss logic and the tag-state RAMs.
// PARAMETERS
//  AWIDTH    16  request address width
//  INDEX_LSB 2   LSB of the set index within the address
//  INDEX_W   3   set index width (8 sets)
// PORTS
//  clock          in   1       sole clock; all logic on posedge
//  reset          in   1       synchronous, active-high
//  cpu_req        in   1       CPU op request; level, held until cpu_done
//  cpu_wr         in   1       1=write (store), 0=read (load)
//  cpu_addr       in   AWIDTH  CPU address
//  cpu_way        in   1       way selected by hit/replacement logic
//  cpu_done       out  1       1-cycle pulse: CPU op complete
//  cpu_bus_cmd    out  2       valid with cpu_done: 00 none, 01 BusRd, 10 BusRdX, 11 BusUpgr
//  snp_req        in   1       snoop request; level, held until snp_done
//  snp_excl       in   1       1=BusRdX/BusUpgr seen, 0=BusRd seen
//  snp_addr       in   AWIDTH  snooped address
//  snp_hit        in   1       snooped line present in cache
//  snp_way        in   1       way holding the snooped line (ignored if !snp_hit)
//  snp_done       out  1       1-cycle pulse: snoop op complete
//  snp_flush      out  1       valid with snp_done: line was M, data must be flushed
//  tag_index      out  INDEX_W set index to both tag-state RAMs
//  tag_way        out  1       RAM select: 0=way0, 1=way1
//  tag_we         out  1       write strobe for selected RAM
//  tag_state_wr   out  2       state written when tag_we=1
//  tag_state_rd   in   2       selected RAM state; valid the cycle after tag_index/tag_way are driven
//  old_state      out  2       valid with either done: state before the op
//  new_state      out  2       valid with either done: state after the op
// BEHAVIOUR
//  Encoding: I=00, S=01, M=10; 11 read back is treated as I.
//  Reset: FSM->IDLE; all outputs 0; last_grant=snoop, so CPU wins the first tie. Reset mid-op aborts the op with
//   no tag_we and no done. Requesters still holding req are re-accepted after reset.
//  FSM IDLE -> RD -> WR -> RESP -> IDLE. Each op takes 4 cycles. A request is sampled only in IDLE.
//  IDLE: if any req, grant and latch op, index, way. Then go to RD. Snoop miss skips RD/WR and goes straight to RESP.
//  Arbitration: snoop-only or CPU-only wins. If both are pending, the winner is the requester opposite last_grant.
//   This alternates the ports, so CPU is never starved by back-to-back snoops.
//  RD: drive tag_index = addr[INDEX_LSB+INDEX_W-1:INDEX_LSB] and tag_way; tag_we=0.
//  WR: sample tag_state_rd and compute next state. tag_we=1 only if new!=old.
//  RESP: done pulse for the granted port, with old_state, new_state, cpu_bus_cmd / snp_flush. tag_we=0.
//  CPU read:  I->S BusRd; S->S none; M->M none.
//  CPU write: I->M BusRdX; S->M BusUpgr; M->M none.
//  Snoop BusRd:       M->S flush; S->S; I->I.
//  Snoop BusRdX/Upgr: M->I flush; S->I; I->I.
//  Snoop miss: old=new=I, no flush, no tag access.
//  tag_index, tag_way and tag_state_wr hold the latched values from RD through RESP. Outputs are 0 in IDLE.
//  Done never asserts for both ports in the same cycle.
//  Request fields must stay stable while req is high. A req dropped before done is ignored once granted;
//   the op still completes.
// TESTING
//  T1: reset; CPU read index 5 way0, RAM holds I -> RD cyc2; tag_we with 01 in WR; cpu_done cyc4; bus_cmd=01; old=00 new=01.
//  T2: CPU write to S line -> tag_we state 10, bus_cmd=11. Repeat on M line -> tag_we never asserted, bus_cmd=00.
//  T3: snp BusRdX hit on M in way1 -> tag_way=1, write 00, snp_done with flush=1. Snoop miss -> snp_done 2 cycles after
//   grant, no tag_we.
//  T4: cpu_req and snp_req held together, back to back -> grants alternate CPU, SNP, CPU, SNP; done pulses spaced 4 cycles.
//  T5: reset asserted during WR of a CPU write -> no done; outputs 0 next cycle; held cpu_req is re-run from IDLE.
//  T6: RAM returns 11 -> treated as I: CPU read writes 01 with BusRd; snoop gives new=00 with no flush.

Source files
------------

// File: rtl/msi_tag_state_ctrl_if.sv
// Purpose : bundles the CPU port, snoop port and tag-state RAM port of the MSI tag-state controller.
// Latency : none, wiring only.
// Backpressure: req levels are held by the requesters until the matching done pulse.
// Ports   : cpu_* (CPU request/response), snp_* (snoop request/response),
//           tag_* (tag-state RAM index/way/write/read), old_state/new_state (result report).
//           master = requesters plus tag RAM side, slave = the controller.
interface msi_tag_state_ctrl_if #(
  parameter int AWIDTH  = 16,
  parameter int INDEX_W = 3
);
  logic               cpu_req;
  logic               cpu_wr;
  logic [AWIDTH-1:0]  cpu_addr;
  logic               cpu_way;
  logic               cpu_done;
  logic [1:0]         cpu_bus_cmd;

  logic               snp_req;
  logic               snp_excl;
  logic [AWIDTH-1:0]  snp_addr;
  logic               snp_hit;
  logic               snp_way;
  logic               snp_done;
  logic               snp_flush;

  logic [INDEX_W-1:0] tag_index;
  logic               tag_way;
  logic               tag_we;
  logic [1:0]         tag_state_wr;
  logic [1:0]         tag_state_rd;

  logic [1:0]         old_state;
  logic [1:0]         new_state;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_way,
    input  cpu_done, cpu_bus_cmd,
    output snp_req, snp_excl, snp_addr, snp_hit, snp_way,
    input  snp_done, snp_flush,
    input  tag_index, tag_way, tag_we, tag_state_wr,
    output tag_state_rd,
    input  old_state, new_state
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_way,
    output cpu_done, cpu_bus_cmd,
    input  snp_req, snp_excl, snp_addr, snp_hit, snp_way,
    output snp_done, snp_flush,
    output tag_index, tag_way, tag_we, tag_state_wr,
    input  tag_state_rd,
    output old_state, new_state
  );
endinterface

// File: rtl/msi_tag_state_ctrl.sv
// Purpose : arbitrates CPU vs snoop and performs one read-modify-write of the MSI state field of the 2-way tag arrays.
// Latency : 4 cycles per op (IDLE grant, RD, WR, RESP done); snoop miss takes 2 (IDLE grant, RESP done).
// Backpressure: requests are levels sampled only in IDLE; a requester simply waits, holding req, until its done pulse.
// Ports   : i_clock, i_reset (sync, active-high); io_bus carries the CPU port, snoop port,
//           tag-state RAM port and the old/new state report (see msi_tag_state_ctrl_if).
module msi_tag_state_ctrl #(
  parameter int AWIDTH    = 16,
  parameter int INDEX_LSB = 2,
  parameter int INDEX_W   = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  msi_tag_state_ctrl_if.slave io_bus
);

  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b10;
  localparam logic [1:0] MSI_X = 2'b11;

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_BUSRD   = 2'b01;
  localparam logic [1:0] CMD_BUSRDX  = 2'b10;
  localparam logic [1:0] CMD_BUSUPGR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_snp;
  logic               r_is_snp;
  logic               r_wr;
  logic [INDEX_W-1:0] r_index;
  logic               r_way;
  logic [1:0]         r_old;
  logic [1:0]         r_new;
  logic [1:0]         r_cmd;
  logic               r_flush;

  logic               w_grant_cpu;
  logic               w_grant_snp;
  logic [INDEX_W-1:0] w_cpu_index;
  logic [INDEX_W-1:0] w_snp_index;
  logic [1:0]         w_old;
  logic [1:0]         w_new;
  logic [1:0]         w_cmd;
  logic               w_flush;
  logic [AWIDTH-1:0]  w_unused_addr;

  assign w_cpu_index   = io_bus.cpu_addr[INDEX_LSB +: INDEX_W];
  assign w_snp_index   = io_bus.snp_addr[INDEX_LSB +: INDEX_W];
  assign w_unused_addr = io_bus.cpu_addr ^ io_bus.snp_addr;

  // On a tie the port opposite the last grant wins, so the two ports alternate.
  assign w_grant_snp = io_bus.snp_req & (~io_bus.cpu_req | ~r_last_snp);
  assign w_grant_cpu = io_bus.cpu_req & ~w_grant_snp;

  // Next MSI state from the value read back in WR; the unused 11 code reads as I.
  always_comb begin
    w_old   = (io_bus.tag_state_rd == MSI_X) ? MSI_I : io_bus.tag_state_rd;
    w_new   = w_old;
    w_cmd   = CMD_NONE;
    w_flush = 1'b0;
    if (!r_is_snp) begin
      if (r_wr) begin
        if (w_old == MSI_I) begin
          w_new = MSI_M;
          w_cmd = CMD_BUSRDX;
        end else if (w_old == MSI_S) begin
          w_new = MSI_M;
          w_cmd = CMD_BUSUPGR;
        end
      end else if (w_old == MSI_I) begin
        w_new = MSI_S;
        w_cmd = CMD_BUSRD;
      end
    end else begin
      if (w_old == MSI_M) begin
        w_flush = 1'b1;
      end
      if (w_old != MSI_I) begin
        w_new = r_wr ? MSI_I : MSI_S;
      end
    end
  end

  // Next-state and outputs. Everything is 0 in IDLE; tag_we and done are
  // masked while reset is high so an aborted op leaves the RAM untouched.
  always_comb begin
    w_state_nxt         = r_state;
    io_bus.cpu_done     = 1'b0;
    io_bus.cpu_bus_cmd  = CMD_NONE;
    io_bus.snp_done     = 1'b0;
    io_bus.snp_flush    = 1'b0;
    io_bus.tag_index    = '0;
    io_bus.tag_way      = 1'b0;
    io_bus.tag_we       = 1'b0;
    io_bus.tag_state_wr = MSI_I;
    io_bus.old_state    = MSI_I;
    io_bus.new_state    = MSI_I;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_snp && !io_bus.snp_hit) begin
          w_state_nxt = ST_RESP;
        end else if (w_grant_snp || w_grant_cpu) begin
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        w_state_nxt      = ST_WR;
        io_bus.tag_index = r_index;
        io_bus.tag_way   = r_way;
      end
      ST_WR: begin
        w_state_nxt         = ST_RESP;
        io_bus.tag_index    = r_index;
        io_bus.tag_way      = r_way;
        io_bus.tag_state_wr = w_new;
        io_bus.tag_we       = (w_new != w_old) & ~i_reset;
      end
      ST_RESP: begin
        w_state_nxt         = ST_IDLE;
        io_bus.tag_index    = r_index;
        io_bus.tag_way      = r_way;
        io_bus.tag_state_wr = r_new;
        io_bus.old_state    = r_old;
        io_bus.new_state    = r_new;
        io_bus.cpu_done     = ~r_is_snp & ~i_reset;
        io_bus.snp_done     = r_is_snp & ~i_reset;
        io_bus.cpu_bus_cmd  = r_is_snp ? CMD_NONE : r_cmd;
        io_bus.snp_flush    = r_is_snp & r_flush;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_last_snp <= 1'b1;
      r_is_snp   <= 1'b0;
      r_wr       <= 1'b0;
      r_index    <= '0;
      r_way      <= 1'b0;
      r_old      <= MSI_I;
      r_new      <= MSI_I;
      r_cmd      <= CMD_NONE;
      r_flush    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && (w_grant_cpu || w_grant_snp)) begin
        r_is_snp   <= w_grant_snp;
        r_last_snp <= w_grant_snp;
        // A snoop miss never touches the RAM, so its index/way stay 0 and it reports I->I.
        r_old      <= MSI_I;
        r_new      <= MSI_I;
        r_cmd      <= CMD_NONE;
        r_flush    <= 1'b0;
        if (w_grant_snp) begin
          r_wr    <= io_bus.snp_excl;
          r_index <= io_bus.snp_hit ? w_snp_index : '0;
          r_way   <= io_bus.snp_hit & io_bus.snp_way;
        end else begin
          r_wr    <= io_bus.cpu_wr;
          r_index <= w_cpu_index;
          r_way   <= io_bus.cpu_way;
        end
      end
      if (r_state == ST_WR) begin
        r_old   <= w_old;
        r_new   <= w_new;
        r_cmd   <= w_cmd;
        r_flush <= w_flush;
      end
    end
  end

endmodule

// File: tb/tb_msi_tag_state_ctrl.sv
// Purpose : self-checking bench for msi_tag_state_ctrl with a behavioural 2-way tag-state RAM.
// Latency : expects done 3 cycles after the request cycle (1 for a snoop miss).
// Backpressure: requests are held until done, then dropped on the same falling edge.
module tb_msi_tag_state_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msi_tag_state_ctrl_if #(.AWIDTH(16), .INDEX_W(3)) bus ();

  msi_tag_state_ctrl #(.AWIDTH(16), .INDEX_LSB(2), .INDEX_W(3)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  // Tag-state RAM model: registered read, write on tag_we, plus a preload port.
  logic [1:0] ram [0:1][0:7];
  logic       ld_en  = 1'b0;
  logic       ld_way = 1'b0;
  logic [2:0] ld_idx = '0;
  logic [1:0] ld_val = '0;
  always @(posedge clk) begin
    if (ld_en) ram[ld_way][ld_idx] <= ld_val;
    else if (bus.tag_we) ram[bus.tag_way][bus.tag_index] <= bus.tag_state_wr;
    bus.tag_state_rd <= ram[bus.tag_way][bus.tag_index];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          snp;
    bit          wr;
    bit          hit;
    logic [15:0] addr;
    bit          way;
    logic [1:0]  init;
    logic [1:0]  e_old;
    logic [1:0]  e_new;
    logic [1:0]  e_cmd;
    bit          e_flush;
    bit          e_we;
    logic [1:0]  e_ram;
  } vec_t;

  typedef struct {
    bit         snp;
    logic [1:0] old_s;
    logic [1:0] new_s;
    logic [1:0] cmd;
    bit         flush;
    bit         we;
    logic [2:0] idx;
    bit         way;
    bit         loc;
    int         start;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[14];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input bit snp, input bit wr, input bit hit, input logic [15:0] addr,
                              input bit way, input logic [1:0] init, input logic [1:0] e_old,
                              input logic [1:0] e_new, input logic [1:0] e_cmd, input bit e_flush,
                              input bit e_we, input logic [1:0] e_ram);
    vec_t v;
    v.snp = snp; v.wr = wr; v.hit = hit; v.addr = addr; v.way = way; v.init = init;
    v.e_old = e_old; v.e_new = e_new; v.e_cmd = e_cmd; v.e_flush = e_flush; v.e_we = e_we; v.e_ram = e_ram;
    return v;
  endfunction

  function automatic int outs();
    return int'({bus.cpu_done, bus.snp_done, bus.tag_we, bus.tag_way, bus.tag_index, bus.tag_state_wr,
                 bus.old_state, bus.new_state, bus.cpu_bus_cmd, bus.snp_flush});
  endfunction

  // Pops one expectation per done pulse and checks everything seen since the previous one.
  task automatic monitor();
    int         we_cnt = 0;
    logic [1:0] we_val = '0;
    logic       we_way = 1'b0;
    logic [2:0] we_idx = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (bus.tag_we) begin
        we_cnt++;
        we_val = bus.tag_state_wr;
        we_way = bus.tag_way;
        we_idx = bus.tag_index;
      end
      if (bus.cpu_done || bus.snp_done) begin
        check("single_done", int'(bus.cpu_done && bus.snp_done), 0);
        check("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("done_port", int'(bus.snp_done), int'(e.snp));
          check("old_state", bus.old_state, e.old_s);
          check("new_state", bus.new_state, e.new_s);
          if (e.snp) check("snp_flush", bus.snp_flush, e.flush);
          else check("cpu_bus_cmd", bus.cpu_bus_cmd, e.cmd);
          check("tag_we_count", we_cnt, int'(e.we));
          if (e.we && we_cnt > 0) begin
            check("tag_wr_state", we_val, e.new_s);
            check("tag_wr_way", we_way, e.way);
            check("tag_wr_index", we_idx, e.idx);
          end
          if (e.loc) begin
            check("resp_index", bus.tag_index, e.idx);
            check("resp_way", bus.tag_way, e.way);
            check("resp_state_wr", bus.tag_state_wr, e.new_s);
          end
          check("done_latency", cyc - e.start, e.lat);
        end
        we_cnt = 0;
      end
    end
  endtask

  task automatic preload(input bit way, input logic [2:0] idx, input logic [1:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_way = way; ld_idx = idx; ld_val = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_done(input bit snp, input int max, output int got);
    got = 0;
    for (int k = 0; k < max && got == 0; k++) begin
      @(negedge clk);
      if (snp ? bus.snp_done : bus.cpu_done) got = 1;
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v, input int start);
    exp_t       e;
    logic [15:0] a;
    a = v.addr;
    e.snp = v.snp; e.old_s = v.e_old; e.new_s = v.e_new; e.cmd = v.e_cmd; e.flush = v.e_flush;
    e.we = v.e_we; e.idx = a[4:2]; e.way = v.way; e.loc = !v.snp || v.hit;
    e.start = start; e.lat = (v.snp && !v.hit) ? 1 : 3;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    if (v.snp) begin
      bus.snp_excl = v.wr; bus.snp_addr = v.addr; bus.snp_hit = v.hit; bus.snp_way = v.way; bus.snp_req = 1'b1;
    end else begin
      bus.cpu_wr = v.wr; bus.cpu_addr = v.addr; bus.cpu_way = v.way; bus.cpu_req = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          got;
    logic [15:0] a;
    a = v.addr;
    preload(v.way, a[4:2], v.init);
    sb.push_back(mk_exp(v, cyc));
    drive(v);
    wait_done(v.snp, 20, got);
    check("done_seen", got, 1);
    bus.cpu_req = 1'b0;
    bus.snp_req = 1'b0;
    check("ram_after_op", ram[v.way][a[4:2]], v.e_ram);
  endtask

  initial begin
    int   got;
    int   c0;
    vec_t v;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_way = 1'b0;
    bus.snp_req = 1'b0; bus.snp_excl = 1'b0; bus.snp_addr = '0; bus.snp_hit = 1'b0; bus.snp_way = 1'b0;

    //      snp wr hit addr      way init  old   new   cmd  fl we  ram
    vt[0]  = mk(0, 0, 1, 16'h0014, 0, 2'd0, 2'd0, 2'd1, 2'd1, 0, 1, 2'd1); // read I -> S BusRd
    vt[1]  = mk(0, 1, 1, 16'hA308, 1, 2'd1, 2'd1, 2'd2, 2'd3, 0, 1, 2'd2); // write S -> M BusUpgr
    vt[2]  = mk(0, 1, 1, 16'hA308, 1, 2'd2, 2'd2, 2'd2, 2'd0, 0, 0, 2'd2); // write M -> M
    vt[3]  = mk(0, 0, 1, 16'h7FE3, 1, 2'd2, 2'd2, 2'd2, 2'd0, 0, 0, 2'd2); // read M -> M
    vt[4]  = mk(0, 0, 1, 16'h0018, 0, 2'd1, 2'd1, 2'd1, 2'd0, 0, 0, 2'd1); // read S -> S
    vt[5]  = mk(0, 1, 1, 16'h001C, 0, 2'd0, 2'd0, 2'd2, 2'd2, 0, 1, 2'd2); // write I -> M BusRdX
    vt[6]  = mk(0, 0, 1, 16'h0004, 1, 2'd3, 2'd0, 2'd1, 2'd1, 0, 1, 2'd1); // read 11 as I -> S BusRd
    vt[7]  = mk(1, 1, 1, 16'h0010, 1, 2'd2, 2'd2, 2'd0, 2'd0, 1, 1, 2'd0); // snp excl M -> I flush
    vt[8]  = mk(1, 0, 1, 16'hF018, 0, 2'd2, 2'd2, 2'd1, 2'd0, 1, 1, 2'd1); // snp rd M -> S flush
    vt[9]  = mk(1, 1, 1, 16'h000C, 0, 2'd1, 2'd1, 2'd0, 2'd0, 0, 1, 2'd0); // snp excl S -> I
    vt[10] = mk(1, 0, 1, 16'h0034, 1, 2'd1, 2'd1, 2'd1, 2'd0, 0, 0, 2'd1); // snp rd S -> S
    vt[11] = mk(1, 0, 1, 16'h001C, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0); // snp rd I -> I
    vt[12] = mk(1, 1, 1, 16'h0008, 0, 2'd3, 2'd0, 2'd0, 2'd0, 0, 0, 2'd3); // snp excl 11 as I, no write
    vt[13] = mk(1, 1, 0, 16'h0014, 1, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0, 2'd2); // snp miss, RAM untouched

    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 0);

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Both ports held together: last grant was the snoop miss, so CPU goes first.
    preload(1'b0, 3'd1, 2'd0);
    preload(1'b1, 3'd2, 2'd2);
    c0 = cyc;
    sb.push_back(mk_exp(mk(0, 0, 1, 16'h0004, 0, 2'd0, 2'd0, 2'd1, 2'd1, 0, 1, 2'd1), c0));
    sb.push_back(mk_exp(mk(1, 0, 1, 16'h0008, 1, 2'd2, 2'd2, 2'd1, 2'd0, 1, 1, 2'd1), c0 + 4));
    sb.push_back(mk_exp(mk(0, 0, 1, 16'h0004, 0, 2'd1, 2'd1, 2'd1, 2'd0, 0, 0, 2'd1), c0 + 8));
    sb.push_back(mk_exp(mk(1, 0, 1, 16'h0008, 1, 2'd1, 2'd1, 2'd1, 2'd0, 0, 0, 2'd1), c0 + 12));
    drive(mk(0, 0, 1, 16'h0004, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0));
    drive(mk(1, 0, 1, 16'h0008, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0));
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (bus.cpu_done || bus.snp_done) got++;
    end
    bus.cpu_req = 1'b0;
    bus.snp_req = 1'b0;
    check("alt_done_count", got, 4);

    // Reset during WR of a CPU write: no write, no done, then the held request reruns.
    preload(1'b0, 3'd3, 2'd1);
    v = mk(0, 1, 1, 16'h000C, 0, 2'd1, 2'd1, 2'd2, 2'd3, 0, 1, 2'd2);
    drive(v);
    @(negedge clk);
    check("rd_index", bus.tag_index, 3);
    check("rd_tag_we", bus.tag_we, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_wr_tag_we", bus.tag_we, 0);
    check("rst_wr_done", int'(bus.cpu_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", outs(), 0);
    check("post_rst_ram", ram[0][3], 1);
    sb.push_back(mk_exp(v, cyc));
    wait_done(1'b0, 20, got);
    check("rerun_done_seen", got, 1);
    bus.cpu_req = 1'b0;
    check("rerun_ram", ram[0][3], 2);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
